// File: rtl/clock_divider_seven_seg_if.sv
// Display/tick bundle between the seconds-counter board logic and the divider/decoder leaf.
// The requester (master) drives val and observes seg, clock_out and the divide count.
interface clock_divider_seven_seg_if #(
   parameter int CNT_W = 24
);
   logic [3:0]       val;
   logic [7:0]       seg;
   logic             clock_out;
   logic [CNT_W-1:0] dbg_cnt;

   modport master (
      output val,
      input  seg,
      input  clock_out,
      input  dbg_cnt
   );

   modport slave (
      input  val,
      output seg,
      output clock_out,
      output dbg_cnt
   );
endinterface

// File: rtl/clock_divider_seven_seg.sv
// Divides clock_in to a 50% duty tick (clock_out) and decodes a nibble to an
// active-low seven-segment pattern; the decoder is independent of clock and reset.
module clock_divider_seven_seg #(
   parameter int HALF_PERIOD = 5000000,
   parameter int CNT_W       = 24
) (
   input  logic                     clock_in,
   input  logic                     reset_n,
   clock_divider_seven_seg_if.slave bus
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HALF_PERIOD - 1);

   logic [CNT_W-1:0] cnt;
   logic             clock_q;
   logic [7:0]       seg_d;

   // clock_out toggles when a full half-period of clock_in edges has elapsed.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         cnt     <= '0;
         clock_q <= 1'b0;
      end else if (cnt == LAST_CNT) begin
         cnt     <= '0;
         clock_q <= ~clock_q;
      end else begin
         cnt     <= cnt + 1'b1;
      end
   end

   assign bus.clock_out = clock_q;
   assign bus.dbg_cnt   = cnt;

   // Code 15 and any unknown input fall to blank, which keeps the dp off.
   always_comb begin
      seg_d = 8'hFF;
      case (bus.val)
         4'd0:    seg_d = 8'hC0;
         4'd1:    seg_d = 8'hF9;
         4'd2:    seg_d = 8'hA4;
         4'd3:    seg_d = 8'hB0;
         4'd4:    seg_d = 8'h99;
         4'd5:    seg_d = 8'h92;
         4'd6:    seg_d = 8'h82;
         4'd7:    seg_d = 8'hF8;
         4'd8:    seg_d = 8'h80;
         4'd9:    seg_d = 8'h90;
         4'd10:   seg_d = 8'h88;
         4'd11:   seg_d = 8'h83;
         4'd12:   seg_d = 8'hC6;
         4'd13:   seg_d = 8'hA1;
         4'd14:   seg_d = 8'h86;
         default: seg_d = 8'hFF;
      endcase
   end

   assign bus.seg = seg_d;

endmodule

// File: tb/tb_clock_divider_seven_seg.sv
// Directed bench: divide-by-8 and divide-by-2 instances plus a full decoder sweep.
module tb_clock_divider_seven_seg;

   logic clock_in = 1'b0;
   logic reset_n4 = 1'b1;
   logic reset_n1 = 1'b1;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [7:0] seg_table [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'hFF
   };

   clock_divider_seven_seg_if #(.CNT_W(24)) bus4 ();
   clock_divider_seven_seg_if #(.CNT_W(24)) bus1 ();

   clock_divider_seven_seg #(.HALF_PERIOD(4), .CNT_W(24)) dut4 (
      .clock_in (clock_in),
      .reset_n  (reset_n4),
      .bus      (bus4.slave)
   );

   clock_divider_seven_seg #(.HALF_PERIOD(1), .CNT_W(24)) dut1 (
      .clock_in (clock_in),
      .reset_n  (reset_n1),
      .bus      (bus1.slave)
   );

   always #5 clock_in = ~clock_in;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock_in);
      #1;
   endtask

   initial begin
      bus4.val = 4'd0;
      bus1.val = 4'd0;

      // Reset both instances; decoder sweep on bus4 while it is held in reset.
      #1;
      reset_n4 = 1'b0;
      reset_n1 = 1'b0;
      #1;
      check("rst_clk_async", {31'd0, bus4.clock_out}, 32'd0);
      for (int i = 0; i < 3; i++) tick();
      check("rst_clk", {31'd0, bus4.clock_out}, 32'd0);
      check("rst_cnt", bus4.dbg_cnt, 32'd0);
      for (int v = 0; v < 16; v++) begin
         bus4.val = 4'(v);
         #1;
         check($sformatf("seg_rst_%0d", v), {24'd0, bus4.seg}, {24'd0, seg_table[v]});
         check($sformatf("dp_rst_%0d", v), {31'd0, bus4.seg[7]}, 32'd1);
      end
      bus4.val = 4'bxxxx;
      #1;
      check("dp_x", {31'd0, bus4.seg[7]}, 32'd1);
      check("rst_hold_clk", {31'd0, bus4.clock_out}, 32'd0);

      // HALF_PERIOD=4: release between edges; rises at edge 4, falls at 8, rises at 12.
      @(negedge clock_in);
      reset_n4 = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         tick();
         check($sformatf("hp4_clk_e%0d", k), {31'd0, bus4.clock_out}, ((k / 4) % 2 == 1) ? 32'd1 : 32'd0);
         check($sformatf("hp4_cnt_e%0d", k), bus4.dbg_cnt, 32'(k % 4));
         bus4.val = 4'((k * 7) % 16);
         #1;
         check($sformatf("hp4_seg_e%0d", k), {24'd0, bus4.seg}, {24'd0, seg_table[(k * 7) % 16]});
      end

      // Mid-period async reset: clock_out high, cnt=2, asserted between edges.
      @(negedge clock_in);
      check("pre_async_clk", {31'd0, bus4.clock_out}, 32'd1);
      check("pre_async_cnt", bus4.dbg_cnt, 32'd2);
      reset_n4 = 1'b0;
      #1;
      check("async_clk", {31'd0, bus4.clock_out}, 32'd0);
      check("async_cnt", bus4.dbg_cnt, 32'd0);
      tick();
      tick();
      check("async_hold_clk", {31'd0, bus4.clock_out}, 32'd0);
      @(negedge clock_in);
      reset_n4 = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         check($sformatf("post_async_e%0d", k), {31'd0, bus4.clock_out}, (k >= 4) ? 32'd1 : 32'd0);
      end

      // HALF_PERIOD=1: divide-by-2, with val changing every cycle.
      @(negedge clock_in);
      reset_n1 = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         check($sformatf("hp1_clk_e%0d", k), {31'd0, bus1.clock_out}, 32'(k % 2));
         check($sformatf("hp1_cnt_e%0d", k), bus1.dbg_cnt, 32'd0);
         bus1.val = 4'(15 - k);
         #1;
         check($sformatf("hp1_seg_e%0d", k), {24'd0, bus1.seg}, {24'd0, seg_table[15 - k]});
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/clock_divider_seven_seg.md
Name: clock_divider_seven_seg

Overview:
- Timing-and-display leaf for the board-level seconds counter.
- Divides the 10 MHz board clock (clock_in) down to a 1 Hz, 50% duty tick clock (clock_out) that drives the counter logic.
- Also provides an independent combinational hex-to-seven-segment decoder (val -> seg) for the active-low HEX displays, including a blank code used for leading-zero suppression.

Parameters:
- HALF_PERIOD, 5000000, number of clock_in cycles per clock_out half-period. Full period is 2*HALF_PERIOD. Legal range is 1 .. 2^24-1.
- CNT_W, 24, width of the internal divide counter. Must satisfy 2^CNT_W > HALF_PERIOD.

Ports:
- clock_in  input  1  board clock, 10 MHz; the only clock.
- reset_n  input  1  asynchronous, active-low reset for the divider.
- val  input  4  nibble to display.
- clock_out  output  1  divided clock, registered.
- seg  output  8  active-low segment drive: seg[0]=a, seg[1]=b, seg[2]=c, seg[3]=d, seg[4]=e, seg[5]=f, seg[6]=g, seg[7]=dp.

Behaviour:
- Reset and clocking:
  - Single clock domain, clock_in.
  - Reset is asynchronous assert, active-low on reset_n.
  - While reset_n=0: cnt=0 and clock_out=0, immediately, without waiting for a clock edge.
  - Release is sampled on the next rising clock_in.
- Divider:
  - On each rising clock_in with reset_n=1: if cnt==HALF_PERIOD-1, then cnt<=0 and clock_out<=~clock_out; otherwise cnt<=cnt+1.
  - First clock_out rising edge occurs at the HALF_PERIOD-th rising clock_in after release.
  - Thereafter clock_out toggles every HALF_PERIOD cycles, giving exact 50% duty.
  - Defaults (10 MHz in, HALF_PERIOD=5000000) give 1 Hz out.
  - HALF_PERIOD=1: clock_out toggles every cycle (divide-by-2).
  - Reset mid-count discards the partial count; the next period restarts from zero with clock_out low.
  - clock_out is a flop output with no combinational path from inputs.
- Decoder:
  - Purely combinational; seg depends only on val and is unaffected by reset or clock.
  - seg[7] (dp) is always 1 (off).
  - Required codes, hex values of seg[7:0]:
    - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90
    - 10 "A"=88, 11 "b"=83, 12 "C"=C6, 13 "d"=A1, 14 "E"=86
    - 15 = FF (blank, all segments off).
  - Code 15 is reserved as blank for leading-zero suppression; it is not the letter "F".
  - X/Z on val: output is don't-care, but must never light the dp.

Test Plan:
- HALF_PERIOD=4, hold reset_n=0 for 3 cycles, then release:
  - During reset: clock_out=0, cnt=0.
  - clock_out rises at the 4th clock_in edge after release, falls at the 8th, rises at the 12th.
  - High and low phases are each exactly 4 cycles.
- Async reset, HALF_PERIOD=4: drive reset_n low midway between clock edges while clock_out=1 and cnt=2.
  - clock_out=0 at once, before the next edge.
  - After release, the next rise comes exactly 4 edges later.
- HALF_PERIOD=1, release reset: clock_out toggles 0,1,0,1 on successive clock_in edges (period = 2 input cycles).
- Default parameters, simulate 2e7 cycles from release:
  - Exactly 2 rising edges of clock_out, at cycles 5000000 and 15000000.
  - No glitches on clock_out.
- Decoder sweep: apply val=0..15 with reset_n in either state.
  - seg = C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,FF respectively.
  - seg[7]=1 throughout.
- Independence: change val while reset_n=0 and while the divider is running.
  - seg updates combinationally in the same delta.
  - Divider timing is unaffected by val.
